// File: rtl/restart_pulse_gen.sv
// restart_pulse_gen: per-channel synchronizer, debouncer, edge trigger and
// restart pulse/holdoff sequencer, plus a registered OR of all pulses.
module restart_pulse_gen #(
   parameter int N_CH      = 4,
   parameter int DB_CYCLES = 4,
   parameter int PULSE_LEN = 3,
   parameter int HOLDOFF   = 8,
   parameter int EDGE_SEL  = 0
) (
   input  logic            CLK,
   input  logic            RST,
   input  logic [N_CH-1:0] IN,
   input  logic [N_CH-1:0] EN,
   output logic [N_CH-1:0] restart,
   output logic            restart_any,
   output logic [N_CH-1:0] busy
);

   localparam int DBW    = $clog2(DB_CYCLES + 1);
   localparam int PH_MAX = (PULSE_LEN > HOLDOFF) ? PULSE_LEN : HOLDOFF;
   localparam int PCW    = $clog2(PH_MAX + 1);

   // Debounce toggles when the mismatch count would reach DB_CYCLES.
   localparam logic [DBW-1:0] DB_LAST = DBW'(DB_CYCLES - 1);
   localparam logic [PCW-1:0] PL_LAST = PCW'(PULSE_LEN);
   localparam logic [PCW-1:0] HO_LAST = PCW'(HOLDOFF);
   localparam logic [PCW-1:0] PC_ONE  = PCW'(1);

   typedef enum logic [1:0] {ST_IDLE, ST_PULSE, ST_HOLD} state_t;

   logic [N_CH-1:0] sync1_q;
   logic [N_CH-1:0] sync2_q;
   logic            restart_any_q;

   // Two-flop synchronizer for the raw asynchronous inputs.
   always_ff @(posedge CLK) begin
      if (!RST) begin
         sync1_q <= '0;
         sync2_q <= '0;
      end else begin
         sync1_q <= IN;
         sync2_q <= sync1_q;
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < N_CH; gi++) begin : g_ch
         logic           db_q, db_d;
         logic [DBW-1:0] dbc_q, dbc_d;
         logic           trig_q, trig_d;
         state_t         st_q, st_d;
         logic [PCW-1:0] pc_q, pc_d;
         logic           restart_q;
         logic           busy_q;

         // Debounce: count consecutive mismatching cycles, flip the level on the last one.
         always_comb begin
            db_d  = db_q;
            dbc_d = '0;
            if (sync2_q[gi] != db_q) begin
               if (dbc_q == DB_LAST) begin
                  db_d = ~db_q;
               end else begin
                  dbc_d = dbc_q + 1'b1;
               end
            end
         end

         // Edge selection on the debounced level; 2 (and anything else) means both edges.
         always_comb begin
            case (EDGE_SEL)
               0:       trig_d = db_d & ~db_q;
               1:       trig_d = ~db_d & db_q;
               default: trig_d = db_d ^ db_q;
            endcase
         end

         // Sequencer next state: triggers only count in IDLE, counters restart at 1 per phase.
         always_comb begin
            st_d = st_q;
            pc_d = pc_q;
            case (st_q)
               ST_IDLE: begin
                  pc_d = PC_ONE;
                  if (trig_q && EN[gi]) begin
                     st_d = ST_PULSE;
                  end
               end
               ST_PULSE: begin
                  if (pc_q == PL_LAST) begin
                     pc_d = PC_ONE;
                     if (HOLDOFF == 0) begin
                        st_d = ST_IDLE;
                     end else begin
                        st_d = ST_HOLD;
                     end
                  end else begin
                     pc_d = pc_q + 1'b1;
                  end
               end
               ST_HOLD: begin
                  if (pc_q == HO_LAST) begin
                     pc_d = PC_ONE;
                     st_d = ST_IDLE;
                  end else begin
                     pc_d = pc_q + 1'b1;
                  end
               end
               default: begin
                  st_d = ST_IDLE;
                  pc_d = PC_ONE;
               end
            endcase
         end

         // Channel state registers; restart/busy are registered from the next state.
         always_ff @(posedge CLK) begin
            if (!RST) begin
               db_q      <= 1'b0;
               dbc_q     <= '0;
               trig_q    <= 1'b0;
               st_q      <= ST_IDLE;
               pc_q      <= '0;
               restart_q <= 1'b0;
               busy_q    <= 1'b0;
            end else begin
               db_q      <= db_d;
               dbc_q     <= dbc_d;
               trig_q    <= trig_d;
               st_q      <= st_d;
               pc_q      <= pc_d;
               restart_q <= (st_d == ST_PULSE);
               busy_q    <= (st_d != ST_IDLE);
            end
         end

         assign restart[gi] = restart_q;
         assign busy[gi]    = busy_q;
      end
   endgenerate

   // Registered OR of the restart bits, one cycle behind them.
   always_ff @(posedge CLK) begin
      if (!RST) begin
         restart_any_q <= 1'b0;
      end else begin
         restart_any_q <= |restart;
      end
   end

   assign restart_any = restart_any_q;

endmodule

// File: tb/tb_restart_pulse_gen.sv
// Testbench for restart_pulse_gen: countdown-based reference model checked every
// cycle, plus directed scenarios with hand-computed literal expectations.
module tb_restart_pulse_gen;

   localparam int N_CH      = 4;
   localparam int DB_CYCLES = 4;
   localparam int PULSE_LEN = 3;
   localparam int HOLDOFF   = 8;
   localparam int EDGE_SEL  = 0;

   logic            CLK = 1'b0;
   logic            RST;
   logic [N_CH-1:0] IN;
   logic [N_CH-1:0] EN;
   logic [N_CH-1:0] restart;
   logic            restart_any;
   logic [N_CH-1:0] busy;

   int tests = 0;
   int fails = 0;

   restart_pulse_gen #(
      .N_CH(N_CH), .DB_CYCLES(DB_CYCLES), .PULSE_LEN(PULSE_LEN),
      .HOLDOFF(HOLDOFF), .EDGE_SEL(EDGE_SEL)
   ) dut (
      .CLK(CLK), .RST(RST), .IN(IN), .EN(EN),
      .restart(restart), .restart_any(restart_any), .busy(busy)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference model: per channel, a remaining-busy countdown and a run length of
   // synchronized samples that disagree with the debounced level.
   bit            m_valid = 1'b0;
   bit [N_CH-1:0] m_s1, m_s2, m_db, m_trig, m_rst_exp, m_busy_exp, m_nt;
   bit            m_any_exp;
   int            m_run [N_CH];
   int            m_rem [N_CH];

   initial begin
      forever begin
         @(posedge CLK);
         if (!RST) begin
            m_valid = 1'b1;
            m_s1 = '0; m_s2 = '0; m_db = '0; m_trig = '0;
            m_rst_exp = '0; m_busy_exp = '0; m_any_exp = 1'b0;
            for (int i = 0; i < N_CH; i++) begin
               m_run[i] = 0;
               m_rem[i] = 0;
            end
         end else begin
            m_any_exp = |m_rst_exp;
            m_nt = '0;
            for (int i = 0; i < N_CH; i++) begin
               if (m_rem[i] == 0) begin
                  if (m_trig[i] && EN[i]) m_rem[i] = PULSE_LEN + HOLDOFF;
               end else begin
                  m_rem[i] = m_rem[i] - 1;
               end
               m_rst_exp[i]  = (m_rem[i] > HOLDOFF);
               m_busy_exp[i] = (m_rem[i] > 0);
               if (m_s2[i] != m_db[i]) begin
                  m_run[i] = m_run[i] + 1;
                  if (m_run[i] == DB_CYCLES) begin
                     m_db[i]  = ~m_db[i];
                     m_run[i] = 0;
                     if (EDGE_SEL == 0)      m_nt[i] = m_db[i];
                     else if (EDGE_SEL == 1) m_nt[i] = ~m_db[i];
                     else                    m_nt[i] = 1'b1;
                  end
               end else begin
                  m_run[i] = 0;
               end
            end
            m_trig = m_nt;
            m_s2   = m_s1;
            m_s1   = IN;
         end
      end
   end

   // Per-cycle comparison against the model, away from the active edge.
   initial begin
      forever begin
         @(negedge CLK);
         if (m_valid) begin
            chk("model_restart", 32'(restart), 32'(m_rst_exp));
            chk("model_restart_any", 32'(restart_any), 32'(m_any_exp));
            chk("model_busy", 32'(busy), 32'(m_busy_exp));
         end
      end
   end

   int cnt;
   int first;
   int any_cnt;

   initial begin
      RST = 1'b0;
      IN  = '0;
      EN  = '0;

      // Reset with IN low: everything zero during and after reset.
      repeat (2) begin
         @(negedge CLK);
         chk("lit_reset_restart", 32'(restart), 0);
         chk("lit_reset_any", 32'(restart_any), 0);
         chk("lit_reset_busy", 32'(busy), 0);
      end
      RST = 1'b1;
      repeat (5) begin
         @(negedge CLK);
         chk("lit_post_reset_outputs", {restart, busy, restart_any}, 0);
      end
      $display("[TB] txn reset: outputs idle");

      // Basic rising edge on channel 0: latency and pulse/holdoff shape.
      EN    = 4'hF;
      IN[0] = 1'b1;
      for (int k = 1; k <= 20; k++) begin
         @(negedge CLK);
         chk("lit_basic_restart0", 32'(restart[0]), 32'(k >= 7 && k <= 9));
         chk("lit_basic_any", 32'(restart_any), 32'(k >= 8 && k <= 10));
         chk("lit_basic_busy0", 32'(busy[0]), 32'(k >= 7 && k <= 17));
      end
      $display("[TB] txn basic pulse on ch0");

      // Short glitch on channel 1 must be discarded.
      IN[1] = 1'b1;
      repeat (3) @(negedge CLK);
      IN[1] = 1'b0;
      cnt = 0;
      for (int k = 1; k <= 15; k++) begin
         @(negedge CLK);
         cnt += int'(restart[1]);
      end
      chk("lit_glitch_pulses", cnt, 0);
      $display("[TB] txn glitch on ch1: %0d pulse cycles", cnt);

      // Re-toggle while busy: only the first pulse appears.
      IN[0] = 1'b0;
      repeat (12) @(negedge CLK);
      IN[0] = 1'b1;
      cnt = 0;
      first = 0;
      for (int k = 1; k <= 30; k++) begin
         @(negedge CLK);
         if (restart[0] && first == 0) first = k;
         cnt += int'(restart[0]);
         if (k == 4) IN[0] = 1'b0;
         if (k == 8) IN[0] = 1'b1;
         if (k == 15) chk("lit_retoggle_busy_at15", 32'(busy[0]), 1);
      end
      chk("lit_retoggle_busy_count", cnt, 3);
      chk("lit_retoggle_busy_first", first, 7);
      $display("[TB] txn re-toggle while busy: %0d pulse cycles", cnt);

      // Same re-toggle after busy has dropped: one fresh pulse.
      IN[0] = 1'b0;
      repeat (12) @(negedge CLK);
      IN[0] = 1'b1;
      cnt = 0;
      first = 0;
      for (int k = 1; k <= 20; k++) begin
         @(negedge CLK);
         if (restart[0] && first == 0) first = k;
         cnt += int'(restart[0]);
      end
      chk("lit_retoggle_idle_count", cnt, 3);
      chk("lit_retoggle_idle_first", first, 7);
      $display("[TB] txn re-toggle after idle: %0d pulse cycles", cnt);

      // Reset on the second pulse cycle, then re-trigger from IN held high.
      IN[0] = 1'b0;
      repeat (12) @(negedge CLK);
      IN[0] = 1'b1;
      repeat (7) @(negedge CLK);
      chk("lit_abort_pre", 32'(restart[0]), 1);
      RST = 1'b0;
      @(negedge CLK);
      chk("lit_abort_restart0", 32'(restart[0]), 0);
      chk("lit_abort_busy0", 32'(busy[0]), 0);
      chk("lit_abort_any", 32'(restart_any), 0);
      @(negedge CLK);
      RST = 1'b1;
      for (int k = 1; k <= 12; k++) begin
         @(negedge CLK);
         chk("lit_after_abort_restart0", 32'(restart[0]), 32'(k >= 7 && k <= 9));
      end
      $display("[TB] txn reset abort and re-trigger");

      // Simultaneous triggers with channel 2 disabled.
      IN = '0;
      repeat (25) @(negedge CLK);
      EN = 4'b1011;
      IN = 4'b1101;
      any_cnt = 0;
      for (int k = 1; k <= 20; k++) begin
         @(negedge CLK);
         chk("lit_multi_restart2", 32'(restart[2]), 0);
         chk("lit_multi_busy2", 32'(busy[2]), 0);
         chk("lit_multi_restart0", 32'(restart[0]), 32'(k >= 7 && k <= 9));
         chk("lit_multi_restart3", 32'(restart[3]), 32'(k >= 7 && k <= 9));
         any_cnt += int'(restart_any);
      end
      chk("lit_multi_any_count", any_cnt, 3);
      $display("[TB] txn simultaneous ch0/ch3, ch2 disabled: any=%0d cycles", any_cnt);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
